lcd_write_arbiter: RTL and testbench
====================================

// Module: lcd_write_arbiter
// PURPOSE
//   Sequencer/arbiter for the character text LCD (HD44780-style 8-bit bus, write-only).
//   After reset it runs the LCD power-up init sequence, then shares the LCD bus
//   between two requesters (A, B) with round-robin arbitration.
//   It generates every LCD_E/RS/DATA phase from cycle counters.
//   It sits between the display-content logic and the LCD pins.
// PARAMETERS
//   POWERUP_CYC  100  idle cycles after reset before the first init command
//   SETUP_CYC    2    cycles RS/DATA are stable with LCD_E=0 before the E pulse
//   E_HIGH_CYC   4    cycles LCD_E=1
//   HOLD_CYC     2    cycles RS/DATA are held after LCD_E falls
//   EXEC_CYC     40   wait after a normal command or data write
//   CLR_CYC      160  wait after command 0x01 (clear) or 0x02 (home); RS=0 only
// PORTS
//   clk       in   1  system clock
//   rst       in   1  asynchronous, active-low reset
//   req_a     in   1  requester A write request; held until ack_a
//   rs_a      in   1  A register select (0=command, 1=data)
//   data_a    in   8  A byte
//   ack_a     out  1  one-cycle grant/accept pulse for A
//   req_b     in   1  requester B write request; held until ack_b
//   rs_b      in   1  B register select
//   data_b    in   8  B byte
//   ack_b     out  1  one-cycle grant/accept pulse for B
//   busy      out  1  1 whenever state != IDLE
//   init_done out  1  sticky 1 once the init sequence completes
//   LCD_E     out  1  LCD enable strobe
//   LCD_RS    out  1  LCD register select
//   LCD_RW    out  1  LCD read/write; tied 0 (write-only)
//   LCD_DATA  out  8  LCD data bus
// BEHAVIOUR
//   Reset (rst=0, async) values:
//   - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00.
//   - ack_a=ack_b=0, busy=1, init_done=0.
//   - Round-robin pointer favours A. State POWERUP.
//   States: POWERUP, SETUP, EHIGH, HOLD, WAIT, IDLE. INIT is tracked by a 2-bit
//   init index plus an init flag; no separate state is used.
//   Write cycle = SETUP(SETUP_CYC) -> EHIGH(E_HIGH_CYC) -> HOLD(HOLD_CYC) -> WAIT(n):
//   - n = CLR_CYC if latched RS=0 and byte is 8'h01 or 8'h02; otherwise n = EXEC_CYC.
//   - LCD_RS/LCD_DATA change only on entry to SETUP. They hold their value through
//     HOLD and WAIT, and keep their last value while in IDLE.
//   - LCD_E=1 only in EHIGH.
//   Init sequence:
//   - POWERUP lasts POWERUP_CYC cycles.
//   - Then four write cycles with RS=0: 8'h38, 8'h0C, 8'h06, 8'h01, back-to-back
//     (WAIT -> SETUP directly).
//   - After the last WAIT: state -> IDLE, init_done=1.
//   - Requests are ignored (no ack) until then.
//   - With default parameters, IDLE is entered exactly 100+3*48+168 = 412 cycles
//     after the first clk edge with rst=1.
//   Arbitration (evaluated only in IDLE, on each clk edge):
//   - Only req_a=1: grant A. Only req_b=1: grant B.
//   - Both: grant the side the pointer favours. The pointer then flips to the other side.
//   - Granted rs/data are latched on that edge. State -> SETUP.
//   - ack of the granted side is 1 for exactly that next cycle (first SETUP cycle).
//   - A new request can be granted at the earliest 1 IDLE cycle after WAIT ends.
//     Each write occupies 1 + SETUP+EHIGH+HOLD+n cycles.
//   Requester rules:
//   - After ack, the requester may keep req high with new rs/data for the next byte.
//   - req dropped before ack: nothing is written.
//   - Changing rs/data while req=1 before ack: the value sampled on the grant edge wins.
//   - Requests raised while busy are neither lost nor queued; they are evaluated at
//     the next IDLE.
//   Counters: a single down-counter, width $clog2(max parameter)+1. Every parameter
//   must be >=1; reload value = parameter-1.
//   Reset mid-operation (rst low during any state, including EHIGH):
//   - All outputs return immediately to reset values; LCD_E drops asynchronously.
//   - After rst rises, the full init sequence reruns.
//   - No ack is issued for an interrupted write.
// TESTING
//   1. Reset released at t=20ns, 10ns clk:
//      -> LCD_E pulses 4x with LCD_DATA 38,0C,06,01 and RS=0.
//      -> init_done rises 412 cycles after release; ack never asserts before that.
//   2. After init, req_a=1, rs_a=1, data_a=8'h41:
//      -> ack_a 1 cycle; LCD_RS=1, LCD_DATA=41 for 48 cycles.
//      -> LCD_E high for exactly 4 cycles, starting 2 cycles after ack.
//      -> busy returns 0 after 48 cycles.
//   3. req_a and req_b raised in the same cycle (data 8'h41 / 8'h42), both held:
//      -> bytes written in order 41, 42, 41, 42; ack_a and ack_b alternate; never
//         both high in the same cycle.
//   4. req_b=1, rs_b=0, data_b=8'h01:
//      -> WAIT lasts 160 cycles (write total 168).
//      -> Same with rs_b=1: WAIT lasts 40 cycles.
//   5. rst=0 asserted while LCD_E=1 during a user write:
//      -> LCD_E=0 with no clk edge; no ack; after release init reruns with
//         init_done=0 until its end.
//   6. req_a pulsed high 1 cycle while busy, then dropped:
//      -> no ack_a and no LCD_E pulse for that byte; LCD_RW stays 0 throughout.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// HD44780-style write-only LCD sequencer: runs the power-up init sequence, then
// shares the bus between requesters A and B with round-robin arbitration.
module lcd_write_arbiter #(
  parameter int POWERUP_CYC = 100,
  parameter int SETUP_CYC   = 2,
  parameter int E_HIGH_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 40,
  parameter int CLR_CYC     = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       rs_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic       rs_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = maxi(maxi(maxi(POWERUP_CYC, SETUP_CYC), maxi(E_HIGH_CYC, HOLD_CYC)),
                             maxi(EXEC_CYC, CLR_CYC));
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] RLD_POWERUP = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] RLD_SETUP   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] RLD_EHIGH   = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] RLD_HOLD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RLD_EXEC    = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] RLD_CLR     = CW'(CLR_CYC - 1);

  localparam logic [2:0] S_POWERUP = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_EHIGH   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_IDLE    = 3'd5;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          rr_q, rr_d;          // 0 favours A, 1 favours B
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          e_q, e_d;

  logic cnt_zero, long_wait, gnt_a, gnt_b;

  assign cnt_zero  = (cnt_q == '0);
  // Clear and home need the long execution wait; only as commands.
  assign long_wait = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
  assign gnt_a     = req_a && (!req_b || !rr_q);
  assign gnt_b     = req_b && (!req_a ||  rr_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    rr_d        = rr_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    case (state_q)
      S_POWERUP: begin
        if (cnt_zero) begin
          state_d    = S_SETUP;
          cnt_d      = RLD_SETUP;
          init_idx_d = 2'd0;
          rs_d       = 1'b0;
          data_d     = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_EHIGH;
          cnt_d   = RLD_EHIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EHIGH: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = RLD_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_WAIT;
          cnt_d   = long_wait ? RLD_CLR : RLD_EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (init_done_q || (init_idx_q == 2'd3)) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          // Init commands run back-to-back with no IDLE gap.
          state_d    = S_SETUP;
          cnt_d      = RLD_SETUP;
          init_idx_d = init_idx_q + 2'd1;
          rs_d       = 1'b0;
          data_d     = init_cmd(init_idx_q + 2'd1);
        end
      end
      S_IDLE: begin
        if (gnt_a || gnt_b) begin
          state_d = S_SETUP;
          cnt_d   = RLD_SETUP;
          rs_d    = gnt_a ? rs_a : rs_b;
          data_d  = gnt_a ? data_a : data_b;
          ack_a_d = gnt_a;
          ack_b_d = gnt_b;
          if (req_a && req_b) rr_d = !rr_q;
        end
      end
      default: begin
        state_d = S_POWERUP;
        cnt_d   = RLD_POWERUP;
      end
    endcase
  end

  // Registered strobe so the pin is glitch-free; async reset still drops it at once.
  assign e_d = (state_d == S_EHIGH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_POWERUP;
      cnt_q       <= RLD_POWERUP;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      rr_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      rr_q        <= rr_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      e_q         <= e_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign busy      = (state_q != S_IDLE);
  assign init_done = init_done_q;
  assign LCD_E     = e_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: table of single writes plus hand sequences for
// init timing, contention, busy-time pulses and reset during a write.
module tb_lcd_write_arbiter;

  logic       clk, rst;
  logic       req_a, rs_a, ack_a, req_b, rs_b, ack_b;
  logic [7:0] data_a, data_b, LCD_DATA;
  logic       busy, init_done, LCD_E, LCD_RS, LCD_RW;

  lcd_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .rs_a(rs_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .rs_b(rs_b), .data_b(data_b), .ack_b(ack_b),
    .busy(busy), .init_done(init_done),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int e_pulses = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic       side;       // 0 = A, 1 = B
    logic       rs;
    logic [7:0] data;
    int         exp_busy;
    int         exp_e_first;
    int         exp_e_len;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard: every rising LCD_E must match the next expected {RS,DATA}.
  initial begin
    logic prev_e;
    logic [8:0] e;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (LCD_E === 1'b1 && prev_e === 1'b0) begin
        e_pulses++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_write: got rs=%0d data=0x%0h with nothing expected", LCD_RS, LCD_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("sb_byte", {23'd0, LCD_RS, LCD_DATA}, {23'd0, e});
        end
      end
      prev_e = LCD_E;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_E"},    LCD_E,     0);
    chk({tag, "_RS"},   LCD_RS,    0);
    chk({tag, "_RW"},   LCD_RW,    0);
    chk({tag, "_DATA"}, LCD_DATA,  0);
    chk({tag, "_ack"},  {ack_a, ack_b}, 0);
    chk({tag, "_busy"}, busy,      1);
    chk({tag, "_done"}, init_done, 0);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy !== 1'b0 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Caller releases reset on a negedge; counts edges until init_done (and first ack if held).
  task automatic run_init(input bit hold);
    int n = 0, done_n = -1, ack_n = -1, early = 0, p0;
    logic busy_at_done = 1'b1;
    p0 = e_pulses;
    while (n < 600) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (init_done && done_n < 0) begin
        done_n = n;
        busy_at_done = busy;
        chk("init_pulses", e_pulses - p0, 4);
      end
      if (done_n < 0 && (ack_a || ack_b)) early++;
      if (ack_a && ack_n < 0) begin
        ack_n = n;
        req_a = 1'b0;
      end
      if (done_n >= 0 && (!hold || ack_n >= 0)) break;
    end
    chk("init_done_cycle", done_n, 412);
    chk("ack_before_init", early, 0);
    chk("busy_at_init_done", busy_at_done, 0);
    if (hold) chk("first_ack_cycle", ack_n, 413);
  endtask

  task automatic run_write(input vec_t v);
    int k = 0, e_first = -1, e_len = 0, busy_len = 0, unstable = 0, stray = 0;
    logic good_ack = 1'b0;
    wait_idle();
    if (v.side) begin req_b = 1'b1; rs_b = v.rs; data_b = v.data; end
    else        begin req_a = 1'b1; rs_a = v.rs; data_a = v.data; end
    exp_q.push_back({v.rs, v.data});
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        good_ack = v.side ? (ack_b && !ack_a) : (ack_a && !ack_b);
        req_a = 1'b0;
        req_b = 1'b0;
      end else if (ack_a || ack_b) stray++;
      if (LCD_E) begin
        if (e_first < 0) e_first = k;
        e_len++;
      end
      if (busy) busy_len++;
      if ({LCD_RS, LCD_DATA} !== {v.rs, v.data} || LCD_RW !== 1'b0) unstable++;
    end while (busy && k < 400);
    chk("wr_ack", good_ack, 1);
    chk("wr_e_first", e_first, v.exp_e_first);
    chk("wr_e_len", e_len, v.exp_e_len);
    chk("wr_busy_len", busy_len, v.exp_busy);
    chk("wr_bus_stable", unstable, 0);
    chk("wr_stray_ack", stray, 0);
  endtask

  initial begin
    vecs[0] = '{side: 1'b0, rs: 1'b1, data: 8'h41, exp_busy: 48,  exp_e_first: 3, exp_e_len: 4};
    vecs[1] = '{side: 1'b1, rs: 1'b0, data: 8'h01, exp_busy: 168, exp_e_first: 3, exp_e_len: 4};
    vecs[2] = '{side: 1'b1, rs: 1'b1, data: 8'h01, exp_busy: 48,  exp_e_first: 3, exp_e_len: 4};
    vecs[3] = '{side: 1'b0, rs: 1'b0, data: 8'h02, exp_busy: 168, exp_e_first: 3, exp_e_len: 4};
    vecs[4] = '{side: 1'b0, rs: 1'b0, data: 8'h03, exp_busy: 48,  exp_e_first: 3, exp_e_len: 4};
    vecs[5] = '{side: 1'b1, rs: 1'b1, data: 8'h02, exp_busy: 48,  exp_e_first: 3, exp_e_len: 4};
    vecs[6] = '{side: 1'b0, rs: 1'b0, data: 8'h00, exp_busy: 48,  exp_e_first: 3, exp_e_len: 4};

    rst = 1'b0;
    req_a = 1'b0; rs_a = 1'b0; data_a = 8'h00;
    req_b = 1'b0; rs_b = 1'b0; data_b = 8'h00;
    #10;
    chk_reset_vals("reset");

    // Power-up init with no requesters.
    #10;
    push_init();
    rst = 1'b1;
    run_init(1'b0);

    // Contention: both held, expect strict A/B alternation.
    begin
      int acks = 0, both = 0;
      logic [3:0] seq = 4'd0;
      wait_idle();
      req_a = 1'b1; rs_a = 1'b1; data_a = 8'h41;
      req_b = 1'b1; rs_b = 1'b1; data_b = 8'h42;
      exp_q.push_back(9'h141); exp_q.push_back(9'h142);
      exp_q.push_back(9'h141); exp_q.push_back(9'h142);
      for (int i = 0; i < 400 && acks < 4; i++) begin
        @(negedge clk);
        if (ack_a && ack_b) both++;
        if (ack_a || ack_b) begin
          seq = {seq[2:0], ack_b};
          acks++;
        end
      end
      req_a = 1'b0;
      req_b = 1'b0;
      chk("rr_ack_count", acks, 4);
      chk("rr_ack_order", seq, 4'b0101);
      chk("rr_both_acks", both, 0);
    end

    foreach (vecs[i]) run_write(vecs[i]);

    // Single-cycle request while busy must vanish.
    begin
      int p0, a_cnt = 0, rw_cnt = 0, w = 0;
      wait_idle();
      p0 = e_pulses;
      req_b = 1'b1; rs_b = 1'b1; data_b = 8'h43;
      exp_q.push_back(9'h143);
      while (!ack_b && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("pulse_setup_ack_b", ack_b, 1);
      req_b = 1'b0;
      repeat (10) @(negedge clk);
      chk("pulse_busy_before", busy, 1);
      req_a = 1'b1; rs_a = 1'b1; data_a = 8'h44;
      @(negedge clk);
      req_a = 1'b0;
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        if (ack_a) a_cnt++;
        if (LCD_RW !== 1'b0) rw_cnt++;
      end
      chk("pulse_no_ack_a", a_cnt, 0);
      chk("pulse_e_count", e_pulses - p0, 1);
      chk("pulse_rw_low", rw_cnt, 0);
      chk("done_sticky", init_done, 1);
    end

    // Reset while LCD_E is high, then init reruns with A held throughout.
    begin
      int w = 0;
      wait_idle();
      req_a = 1'b1; rs_a = 1'b1; data_a = 8'h41;
      exp_q.push_back(9'h141);
      while (LCD_E !== 1'b1 && w < 20) begin
        @(negedge clk);
        if (ack_a) req_a = 1'b0;
        w++;
      end
      chk("rst_reached_ehigh", LCD_E, 1);
      #2 rst = 1'b0;
      #1;
      chk_reset_vals("midrst");
      repeat (3) begin
        @(negedge clk);
        chk("midrst_no_ack", {ack_a, ack_b}, 0);
      end
      req_a = 1'b1; rs_a = 1'b1; data_a = 8'h55;
      push_init();
      exp_q.push_back(9'h155);
      rst = 1'b1;
      run_init(1'b1);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
